// File: rtl/rtc_pkg.sv
// Shared widths, field limits, the time record type and small helpers for the RTC slice.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX   = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX   = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX  = 5'd23;
  localparam logic [HOUR_W-1:0] HOUR_NOON = 5'd12;

  // One time-of-day value, always held in 24 h form.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } rtc_time_t;

  // Prescaler counter width for a divide ratio; never narrower than one bit.
  function automatic int prescaler_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

  // 24 h hour to display hour: 0 shows as 12, 13..23 fold to 1..11.
  function automatic logic [HOUR_W-1:0] hour_to_disp(input logic [HOUR_W-1:0] h,
                                                     input logic m12);
    logic [HOUR_W-1:0] d;
    d = h;
    if (m12) begin
      if (h == '0) begin
        d = HOUR_NOON;
      end else if (h > HOUR_NOON) begin
        d = h - HOUR_NOON;
      end
    end
    return d;
  endfunction

  // Clamp an out-of-range load value to the field maximum.
  function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] v);
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

  function automatic logic [MIN_W-1:0] sat_min(input logic [MIN_W-1:0] v);
    return (v > MIN_MAX) ? MIN_MAX : v;
  endfunction

  function automatic logic [HOUR_W-1:0] sat_hour(input logic [HOUR_W-1:0] v);
    return (v > HOUR_MAX) ? HOUR_MAX : v;
  endfunction

endpackage

// File: rtl/rtc_if.sv
// Control/status bundle between the set logic (master) and the RTC core (slave).
// Latency: wires only. Backpressure: none, all signals are levels or 1-cycle pulses.
// Optional alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_if;
  import rtc_pkg::*;

  // controls from the set logic
  logic              run_en;
  logic              dir_down;
  logic              load_en;
  logic [HOUR_W-1:0] hour_in;
  logic [MIN_W-1:0]  min_in;
  logic [SEC_W-1:0]  sec_in;
  logic              inc_hour;
  logic              inc_min;
  logic              mode_12h;

  // status towards the display mux
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic [HOUR_W-1:0] hour_disp;
  logic              pm;
  logic              tick;
  logic              min_carry;
  logic              hour_carry;
  logic              day_carry;

`ifdef RTC_ALARM_EN
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic              alarm_on;
  logic              alarm_hit;
`endif

  modport master (
    output run_en, dir_down, load_en, hour_in, min_in, sec_in,
           inc_hour, inc_min, mode_12h,
`ifdef RTC_ALARM_EN
    output alarm_hour, alarm_min, alarm_on,
    input  alarm_hit,
`endif
    input  sec, min, hour, hour_disp, pm, tick,
           min_carry, hour_carry, day_carry
  );

  modport slave (
    input  run_en, dir_down, load_en, hour_in, min_in, sec_in,
           inc_hour, inc_min, mode_12h,
`ifdef RTC_ALARM_EN
    input  alarm_hour, alarm_min, alarm_on,
    output alarm_hit,
`endif
    output sec, min, hour, hour_disp, pm, tick,
           min_carry, hour_carry, day_carry
  );

endinterface

// File: rtl/rtc_tick_gen.sv
// Prescaler: divides clk by DIV and emits a registered 1-cycle tick every DIV cycles.
// Latency: first tick exactly DIV cycles after reset or clr; then every DIV cycles.
// Backpressure: none; clr restarts the count and suppresses any pending tick.
module rtc_tick_gen
  import rtc_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = prescaler_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // Free-running 0..DIV-1 counter; tick is raised on the wrap so it lands DIV cycles apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + PW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_time_core.sv
// Time-of-day counter: 1 Hz prescaler, up/down h:m:s count, load/set pulses, 12/24 h display.
// Latency: time and carries update together one cycle after tick; hour_disp/pm are combinational.
// Backpressure: none. Optional alarm compare is built when RTC_ALARM_EN is defined.
module rtc_time_core
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1
) (
  input logic  clk,
  input logic  rst,
  rtc_if.slave bus
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  rtc_time_t cur_q;
  rtc_time_t cnt_nxt;
  rtc_time_t ld_val;
  logic      wrap_sec;
  logic      wrap_min;
  logic      wrap_hour;
  logic      tick;
  logic      set_evt;
  logic      count_upd;
  logic      min_carry_q;
  logic      hour_carry_q;
  logic      day_carry_q;

  logic [HOUR_W-1:0] hour_inc_val;
  logic [MIN_W-1:0]  min_inc_val;

  // Loads restart the prescaler so the first second after a set is a full second.
  rtc_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.load_en),
    .tick (tick)
  );

  // A tick only counts when nothing with higher priority claims the same cycle.
  assign set_evt   = bus.inc_hour | bus.inc_min;
  assign count_upd = tick & bus.run_en & ~bus.load_en & ~set_evt;

  // Saturated load value and the wrapping single-field set values.
  always_comb begin
    ld_val.hour  = sat_hour(bus.hour_in);
    ld_val.min   = sat_min(bus.min_in);
    ld_val.sec   = sat_sec(bus.sec_in);
    hour_inc_val = (cur_q.hour == HOUR_MAX) ? '0 : cur_q.hour + HOUR_W'(1);
    min_inc_val  = (cur_q.min == MIN_MAX) ? '0 : cur_q.min + MIN_W'(1);
  end

  // Next count value with ripple carries; direction is taken from the tick cycle itself.
  always_comb begin
    cnt_nxt   = cur_q;
    wrap_sec  = 1'b0;
    wrap_min  = 1'b0;
    wrap_hour = 1'b0;
    if (!bus.dir_down) begin
      if (cur_q.sec == SEC_MAX) begin
        cnt_nxt.sec = '0;
        wrap_sec    = 1'b1;
        if (cur_q.min == MIN_MAX) begin
          cnt_nxt.min = '0;
          wrap_min    = 1'b1;
          if (cur_q.hour == HOUR_MAX) begin
            cnt_nxt.hour = '0;
            wrap_hour    = 1'b1;
          end else begin
            cnt_nxt.hour = cur_q.hour + HOUR_W'(1);
          end
        end else begin
          cnt_nxt.min = cur_q.min + MIN_W'(1);
        end
      end else begin
        cnt_nxt.sec = cur_q.sec + SEC_W'(1);
      end
    end else begin
      if (cur_q.sec == '0) begin
        cnt_nxt.sec = SEC_MAX;
        wrap_sec    = 1'b1;
        if (cur_q.min == '0) begin
          cnt_nxt.min = MIN_MAX;
          wrap_min    = 1'b1;
          if (cur_q.hour == '0) begin
            cnt_nxt.hour = HOUR_MAX;
            wrap_hour    = 1'b1;
          end else begin
            cnt_nxt.hour = cur_q.hour - HOUR_W'(1);
          end
        end else begin
          cnt_nxt.min = cur_q.min - MIN_W'(1);
        end
      end else begin
        cnt_nxt.sec = cur_q.sec - SEC_W'(1);
      end
    end
  end

  // Time registers and carry strobes: load > set pulses > counted tick; carries only on a count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q        <= '0;
      min_carry_q  <= 1'b0;
      hour_carry_q <= 1'b0;
      day_carry_q  <= 1'b0;
    end else begin
      min_carry_q  <= 1'b0;
      hour_carry_q <= 1'b0;
      day_carry_q  <= 1'b0;
      if (bus.load_en) begin
        cur_q <= ld_val;
      end else if (set_evt) begin
        if (bus.inc_hour) begin
          cur_q.hour <= hour_inc_val;
        end
        if (bus.inc_min) begin
          cur_q.min <= min_inc_val;
        end
      end else if (count_upd) begin
        cur_q        <= cnt_nxt;
        min_carry_q  <= wrap_sec;
        hour_carry_q <= wrap_min;
        day_carry_q  <= wrap_hour;
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_hit_q;
  logic alarm_match;

  assign alarm_match = bus.alarm_on &&
                       (cnt_nxt.hour == bus.alarm_hour) &&
                       (cnt_nxt.min == bus.alarm_min) &&
                       (cnt_nxt.sec == '0);

  // Alarm fires only from a counted update landing on hh:mm:00, never from loads or sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_hit_q <= count_upd && alarm_match;
    end
  end

  assign bus.alarm_hit = alarm_hit_q;
`endif

  assign bus.sec        = cur_q.sec;
  assign bus.min        = cur_q.min;
  assign bus.hour       = cur_q.hour;
  assign bus.hour_disp  = hour_to_disp(cur_q.hour, bus.mode_12h);
  assign bus.pm         = (cur_q.hour >= HOUR_NOON);
  assign bus.tick       = tick;
  assign bus.min_carry  = min_carry_q;
  assign bus.hour_carry = hour_carry_q;
  assign bus.day_carry  = day_carry_q;

endmodule
